// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, 1-cycle synchronous instruction memory
// interface, 2-entry skid FIFO toward decode, flush redirect and HLT stop.
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OP   = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [15:0] i_brTarget,
  output logic [15:0] o_imAddr,
  output logic        o_imRdEn,
  input  logic [15:0] i_imData,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_hlt
);

  logic [15:0] r_pc;
  logic [15:0] r_inf_pc;
  logic        r_inflight;
  logic        r_halted;
  logic        r_rd;
  logic [1:0]  r_count;
  logic [15:0] r_fifo_instr [2];
  logic [15:0] r_fifo_pc    [2];
  logic [15:0] r_instr;
  logic [15:0] r_pc_out;
  logic        r_valid;

  logic        w_pop;
  logic        w_push;
  logic        w_hlt_push;
  logic        w_issue;
  logic        w_wr;
  logic        w_rd_n;
  logic [1:0]  w_count_n;
  logic [2:0]  w_occupancy;
  logic [2:0]  w_limit;
  logic [15:0] w_pc_n;
  logic        w_halted_n;
  logic [15:0] w_head_instr_n;
  logic [15:0] w_head_pc_n;

  // Handshake, issue decision and next-state of the FIFO head
  always_comb begin
    w_pop       = r_valid & ~i_stall & ~i_flush;
    w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    w_limit     = 3'd2 + {2'b00, w_pop};
    w_issue     = ~i_rst & ~r_halted & ~i_flush & (w_occupancy < w_limit);
    // A response arriving while halted belongs to the read issued alongside the HLT.
    w_push      = r_inflight & ~r_halted & ~i_flush;
    w_hlt_push  = w_push & (i_imData[15:12] == HLT_OP);
    w_wr        = r_rd ^ r_count[0];

    if (i_flush) begin
      w_count_n = 2'd0;
      w_rd_n    = 1'b0;
    end else begin
      w_count_n = r_count + {1'b0, w_push} - {1'b0, w_pop};
      w_rd_n    = r_rd ^ w_pop;
    end

    if (w_push && (w_wr == w_rd_n)) begin
      w_head_instr_n = i_imData;
      w_head_pc_n    = r_inf_pc;
    end else begin
      w_head_instr_n = r_fifo_instr[w_rd_n];
      w_head_pc_n    = r_fifo_pc[w_rd_n];
    end

    if (i_flush) begin
      w_pc_n     = i_brTarget;
      w_halted_n = 1'b0;
    end else if (w_hlt_push) begin
      w_pc_n     = r_inf_pc + 16'd1;
      w_halted_n = 1'b1;
    end else if (w_issue) begin
      w_pc_n     = r_pc + 16'd1;
      w_halted_n = r_halted;
    end else begin
      w_pc_n     = r_pc;
      w_halted_n = r_halted;
    end
  end

  // Fetch PC, in-flight tracking, FIFO storage and registered decode-side outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc            <= RESET_PC;
      r_inf_pc        <= 16'h0000;
      r_inflight      <= 1'b0;
      r_halted        <= 1'b0;
      r_rd            <= 1'b0;
      r_count         <= 2'd0;
      r_fifo_instr[0] <= 16'h0000;
      r_fifo_instr[1] <= 16'h0000;
      r_fifo_pc[0]    <= 16'h0000;
      r_fifo_pc[1]    <= 16'h0000;
      r_instr         <= 16'h0000;
      r_pc_out        <= 16'h0000;
      r_valid         <= 1'b0;
    end else begin
      r_pc       <= w_pc_n;
      r_halted   <= w_halted_n;
      r_inflight <= w_issue;
      r_inf_pc   <= r_pc;
      r_rd       <= w_rd_n;
      r_count    <= w_count_n;
      if (w_push) begin
        r_fifo_instr[w_wr] <= i_imData;
        r_fifo_pc[w_wr]    <= r_inf_pc;
      end else begin
        r_fifo_instr[w_wr] <= r_fifo_instr[w_wr];
        r_fifo_pc[w_wr]    <= r_fifo_pc[w_wr];
      end
      r_valid <= (w_count_n != 2'd0);
      if (w_count_n != 2'd0) begin
        r_instr  <= w_head_instr_n;
        r_pc_out <= w_head_pc_n;
      end else begin
        r_instr  <= 16'h0000;
        r_pc_out <= 16'h0000;
      end
    end
  end

  assign o_imRdEn = w_issue;
  assign o_imAddr = r_pc;
  assign o_instr  = r_instr;
  assign o_pc     = r_pc_out;
  assign o_valid  = r_valid;
  assign o_hlt    = r_halted;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage of the 16-bit pipeline, acting as the producer feeding the decode stage's instruction/PC inputs.
- Maintains the PC and issues reads to a synchronous instruction memory with 1-cycle latency.
- Buffers returned words in a 2-entry skid FIFO so decode stalls never lose data.
- Redirects on taken branch/jump flushes and stops fetching after a HLT opcode.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
HLT_OP, 4'hF, opcode in instr[15:12] that stops fetching

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_stall  in  1  decode cannot accept the head instruction this cycle
i_flush  in  1  taken branch/jump from a later stage; redirect to i_brTarget
i_brTarget  in  16  redirect PC, sampled when i_flush=1
o_imAddr  out  16  instruction memory address (= current fetch PC)
o_imRdEn  out  1  instruction memory read strobe
i_imData  in  16  read data, valid exactly 1 cycle after o_imRdEn
o_instr  out  16  head instruction to decode
o_pc  out  16  PC of o_instr
o_valid  out  1  o_instr/o_pc hold a valid instruction
o_hlt  out  1  HLT fetched; fetch stopped (sticky)

Behaviour:
- State: fetch PC register pc; inflight flag with inflight PC; 2-entry FIFO of {instr, pc}; count (0..2); halted flag.
- Reset, asynchronous: pc=RESET_PC, FIFO empty, count=0, inflight=0, halted=0. Outputs: o_valid=0, o_instr=0, o_pc=0, o_hlt=0. o_imRdEn is forced 0 while i_rst=1.
- pop = o_valid & ~i_stall & ~i_flush.
- issue = ~i_rst & ~halted & ~i_flush & (count + inflight - pop < 2).
- On issue: o_imRdEn=1, o_imAddr=pc, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000), inflight<=1 with inflight PC=pc. Otherwise inflight<=0.
- Response: when inflight=1, i_imData is pushed into the FIFO with the inflight PC, unless it is dropped (see flush and HLT).
- o_valid = (count != 0). o_instr/o_pc show the FIFO head, registered, so a push is visible the following cycle.
- Latency: first fetch is issued in the first cycle after i_rst falls. Its data is sampled one cycle later; o_valid rises on the cycle after that. Sustained throughput is 1 instr/cycle with i_stall=0.
- Stall: FIFO head held stable. Issue continues until count+inflight reaches 2, then stops. The FIFO can never overflow.
- Simultaneous push and pop: count is unchanged; head advances to the next entry.
- Flush (highest priority over stall, push and HLT):
  - FIFO cleared, count=0, o_valid=0 the next cycle.
  - Any in-flight response is discarded the next cycle.
  - pc<=i_brTarget; halted<=0; no issue in the flush cycle.
  - First fetch from the target is issued the cycle after the flush.
- HLT: when a pushed word has instr[15:12]==HLT_OP:
  - halted<=1, and pc<=HLT address+1.
  - Any read issued in the same cycle (the address after the HLT) returns and is dropped.
  - The HLT itself is still delivered on o_instr.
  - o_hlt = halted; it stays high until flush or reset.
- Reset mid-operation: immediate return to reset state; in-flight data is ignored.
- Only a flush can resume from halted; i_stall has no effect on halted.

Test Plan:
- Reset release, memory holds incrementing words, i_stall=0:
  - o_imRdEn high from cycle 0.
  - o_valid high from cycle 2.
  - o_pc = 0,1,2,... one per cycle; o_instr matches memory.
- Hold i_stall=1 for 5 cycles after o_valid:
  - o_instr/o_pc frozen.
  - o_imRdEn drops once count+inflight=2.
  - On release, PCs continue contiguously with no loss or duplication.
- Flush with i_brTarget=16'h0040 while FIFO is full and a read is in flight:
  - o_valid=0 the next cycle.
  - Next o_pc=16'h0040, then 16'h0041.
  - No stale PCs delivered.
- HLT (16'hF000) at address 5:
  - o_pc=5 is delivered, then o_valid=0.
  - o_hlt=1 and stays high; address 6 is never delivered.
  - A later flush to 16'h0010 clears o_hlt and resumes fetch at 16'h0010.
- Wrap: flush to 16'hFFFE:
  - Delivered PCs are FFFE, FFFF, 0000.
- Assert i_rst asynchronously mid-stream:
  - All outputs go to reset values immediately.
  - After release, fetch restarts at RESET_PC.
